// File: rtl/dnn_riscv_cpu.sv
// dnn_riscv_cpu
//   Single-cycle RV32I-subset core for the DNN-inference compute tile, with two
//   custom Q24.8 neuron instructions on opcode 0001011 (funct7 = 0):
//     funct3 000  NMUL : rd = (rs1 * rs2) >>> 8
//     funct3 001  NACT : rd = piecewise-linear sigmoid(rs1)
//   Holds a loadable 128-word instruction memory (not cleared by reset) and a
//   256-byte little-endian data memory (cleared by reset).
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   enb        execute enable; low holds PC, register file and data memory
//   inst_wen   instruction-memory write strobe (independent of rst/enb)
//   inst_addr  instruction-memory word index for writes
//   inst_data  instruction word to write
//   WB_o       value written to rd this cycle, 0 when no register write occurs
module dnn_riscv_cpu #(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_BYTES = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enb,
    input  logic                          inst_wen,
    input  logic [$clog2(IMEM_WORDS)-1:0] inst_addr,
    input  logic [31:0]                   inst_data,
    output logic [31:0]                   WB_o
);

    localparam int IA_W        = $clog2(IMEM_WORDS);
    localparam int DMEM_WORDS  = DMEM_BYTES / 4;
    localparam int DA_W        = $clog2(DMEM_BYTES);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_NEURON = 7'b0001011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [31:0] pc;
    logic [31:0] imem [0:IMEM_WORDS-1];
    logic [31:0] regs [0:31];
    logic [31:0] dmem [0:DMEM_WORDS-1];

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] ld_addr;
    logic [31:0] st_addr;
    logic [31:0] jalr_sum;
    logic signed [63:0] nmul_prod;
    logic [4:0]  shamt_i;
    logic [4:0]  shamt_r;

    logic [31:0] wb_val;
    logic        reg_we;
    logic        mem_we;
    logic        branch_taken;
    logic [31:0] next_pc;

    // Bits of wide intermediates that the datapath intentionally discards.
    logic unused_bits;
    assign unused_bits = ^{nmul_prod[63:40], nmul_prod[7:0],
                           ld_addr[31:DA_W], ld_addr[1:0],
                           st_addr[31:DA_W], st_addr[1:0], jalr_sum[1:0]};

    // Piecewise-linear sigmoid on |x| in Q24.8, mirrored for negative inputs.
    // |0x80000000| stays 0x80000000, which lands in the saturated segment.
    function automatic logic [31:0] sigmoid(input logic [31:0] x);
        logic [31:0] a;
        logic [8:0]  y;
        a = x[31] ? (~x + 32'd1) : x;
        if (a >= 32'h0000_0500) begin
            y = 9'd256;
        end else if (a >= 32'h0000_0260) begin
            y = 9'(a >> 5) + 9'd216;
        end else if (a >= 32'h0000_0100) begin
            y = 9'(a >> 3) + 9'd160;
        end else begin
            y = 9'(a >> 2) + 9'd128;
        end
        if (x[31]) begin
            y = 9'd256 - y;
        end
        return {23'd0, y};
    endfunction

    assign instr   = imem[pc[IA_W+1:2]];
    assign opcode  = instr[6:0];
    assign rd      = instr[11:7];
    assign funct3  = instr[14:12];
    assign rs1     = instr[19:15];
    assign rs2     = instr[24:20];
    assign funct7  = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // x0 is never written, but decode it explicitly so reads never depend on regs[0].
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    assign ld_addr   = rs1_val + imm_i;
    assign st_addr   = rs1_val + imm_s;
    assign jalr_sum  = rs1_val + imm_i;
    assign nmul_prod = $signed(rs1_val) * $signed(rs2_val);
    assign shamt_i   = instr[24:20];
    assign shamt_r   = rs2_val[4:0];

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = (rs1_val == rs2_val);
            3'b001:  branch_taken = (rs1_val != rs2_val);
            3'b100:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  branch_taken = (rs1_val <  rs2_val);
            3'b111:  branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        wb_val  = 32'd0;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        next_pc = pc + 32'd4;
        case (opcode)
            OP_LUI: begin
                reg_we = 1'b1;
                wb_val = imm_u;
            end
            OP_AUIPC: begin
                reg_we = 1'b1;
                wb_val = pc + imm_u;
            end
            OP_JAL: begin
                reg_we  = 1'b1;
                wb_val  = pc + 32'd4;
                next_pc = (pc + imm_j) & 32'hFFFF_FFFC;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    reg_we  = 1'b1;
                    wb_val  = pc + 32'd4;
                    next_pc = {jalr_sum[31:2], 2'b00};
                end
            end
            OP_BRANCH: begin
                // funct3 010/011 are not branches; they fall through as NOPs.
                if (funct3 != 3'b010 && funct3 != 3'b011 && branch_taken) begin
                    next_pc = (pc + imm_b) & 32'hFFFF_FFFC;
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    reg_we = 1'b1;
                    wb_val = dmem[ld_addr[DA_W-1:2]];
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    mem_we = 1'b1;
                end
            end
            OP_IMM: begin
                case (funct3)
                    3'b000: begin reg_we = 1'b1; wb_val = rs1_val + imm_i; end
                    3'b010: begin reg_we = 1'b1; wb_val = {31'd0, $signed(rs1_val) < $signed(imm_i)}; end
                    3'b011: begin reg_we = 1'b1; wb_val = {31'd0, rs1_val < imm_i}; end
                    3'b100: begin reg_we = 1'b1; wb_val = rs1_val ^ imm_i; end
                    3'b110: begin reg_we = 1'b1; wb_val = rs1_val | imm_i; end
                    3'b111: begin reg_we = 1'b1; wb_val = rs1_val & imm_i; end
                    3'b001: begin
                        if (funct7 == F7_ZERO) begin
                            reg_we = 1'b1;
                            wb_val = rs1_val << shamt_i;
                        end
                    end
                    3'b101: begin
                        if (funct7 == F7_ZERO) begin
                            reg_we = 1'b1;
                            wb_val = rs1_val >> shamt_i;
                        end else if (funct7 == F7_ALT) begin
                            reg_we = 1'b1;
                            wb_val = $signed(rs1_val) >>> shamt_i;
                        end
                    end
                    default: reg_we = 1'b0;
                endcase
            end
            OP_REG: begin
                if (funct7 == F7_ZERO) begin
                    reg_we = 1'b1;
                    case (funct3)
                        3'b000:  wb_val = rs1_val + rs2_val;
                        3'b001:  wb_val = rs1_val << shamt_r;
                        3'b010:  wb_val = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
                        3'b011:  wb_val = {31'd0, rs1_val < rs2_val};
                        3'b100:  wb_val = rs1_val ^ rs2_val;
                        3'b101:  wb_val = rs1_val >> shamt_r;
                        3'b110:  wb_val = rs1_val | rs2_val;
                        default: wb_val = rs1_val & rs2_val;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000) begin
                        reg_we = 1'b1;
                        wb_val = rs1_val - rs2_val;
                    end else if (funct3 == 3'b101) begin
                        reg_we = 1'b1;
                        wb_val = $signed(rs1_val) >>> shamt_r;
                    end
                end
            end
            OP_NEURON: begin
                if (funct7 == F7_ZERO) begin
                    if (funct3 == 3'b000) begin
                        // Q24.8 * Q24.8 = Q48.16; bits [39:8] are the Q24.8 result.
                        reg_we = 1'b1;
                        wb_val = nmul_prod[39:8];
                    end else if (funct3 == 3'b001) begin
                        reg_we = 1'b1;
                        wb_val = sigmoid(rs1_val);
                    end
                end
            end
            default: reg_we = 1'b0;
        endcase
    end

    assign WB_o = (reg_we && enb && !rst) ? wb_val : 32'd0;

    // Instruction loading is outside reset so preloaded programs survive it.
    always_ff @(posedge clk) begin
        if (inst_wen) begin
            imem[inst_addr] <= inst_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
            for (int i = 0; i < DMEM_WORDS; i++) begin
                dmem[i] <= 32'd0;
            end
        end else if (enb) begin
            pc <= next_pc;
            if (reg_we && rd != 5'd0) begin
                regs[rd] <= wb_val;
            end
            if (mem_we) begin
                dmem[st_addr[DA_W-1:2]] <= rs2_val;
            end
        end
    end

endmodule

// File: tb/tb_dnn_riscv_cpu.sv
// Testbench for dnn_riscv_cpu: a table of straight-line instructions with
// hand-computed write-back values, plus directed sequences for reset, the
// branch loop, JAL and the enable freeze.
module tb_dnn_riscv_cpu;

    logic        clk;
    logic        rst;
    logic        enb;
    logic        inst_wen;
    logic [6:0]  inst_addr;
    logic [31:0] inst_data;
    logic [31:0] WB_o;

    int checks = 0;
    int errors = 0;

    dnn_riscv_cpu dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .inst_wen  (inst_wen),
        .inst_addr (inst_addr),
        .inst_data (inst_data),
        .WB_o      (WB_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] wb;
    } vec_t;

    vec_t vecs[$];

    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OPREG  = 7'b0110011;
    localparam logic [6:0] OPLOAD = 7'b0000011;
    localparam logic [6:0] OPCUST = 7'b0001011;
    localparam logic [6:0] OPLUI  = 7'b0110111;
    localparam logic [6:0] OPAUI  = 7'b0010111;

    function automatic logic [31:0] ei(input int imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] op);
        logic [31:0] im;
        im = imm;
        return {im[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] er(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] es(input int imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1);
        logic [31:0] im;
        im = imm;
        return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] eb(input int imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
        logic [31:0] im;
        im = imm;
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] ej(input int imm, input logic [4:0] rd);
        logic [31:0] im;
        im = imm;
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] eu(input int imm, input logic [4:0] rd,
                                       input logic [6:0] op);
        logic [31:0] im;
        im = imm;
        return {im[19:0], rd, op};
    endfunction

    task automatic add(input string n, input logic [31:0] ins, input logic [31:0] w);
        vec_t v;
        v.name  = n;
        v.instr = ins;
        v.wb    = w;
        vecs.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: WB_o got %h, expected %h", n, act, exp);
        end
    endtask

    task automatic load(input int addr, input logic [31:0] word);
        inst_wen  = 1'b1;
        inst_addr = 7'(addr);
        inst_data = word;
        @(posedge clk);
        #1;
        inst_wen  = 1'b0;
    endtask

    // Sample the current instruction's write-back, then let it commit.
    task automatic step(input string n, input logic [31:0] exp);
        @(negedge clk);
        chk(n, WB_o, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        enb       = 1'b0;
        inst_wen  = 1'b0;
        inst_addr = 7'd0;
        inst_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_idle", WB_o, 32'd0);

        add("addi_5",      ei(5, 0, 3'b000, 1, OPIMM),                  32'h0000_0005);
        add("addi_neg7",   ei(-7, 1, 3'b000, 2, OPIMM),                 32'hFFFF_FFFE);
        add("lui",         eu(32'h12345, 3, OPLUI),                     32'h1234_5000);
        add("addi_678",    ei(32'h678, 3, 3'b000, 3, OPIMM),            32'h1234_5678);
        add("sw_84",       es(84, 3, 0),                                32'h0000_0000);
        add("lw_84",       ei(84, 0, 3'b010, 4, OPLOAD),                32'h1234_5678);
        add("lw_340_alias",ei(340, 0, 3'b010, 5, OPLOAD),               32'h1234_5678);
        add("lw_85_lowbit",ei(85, 0, 3'b010, 6, OPLOAD),                32'h1234_5678);
        add("addi_200",    ei(32'h200, 0, 3'b000, 7, OPIMM),            32'h0000_0200);
        add("addi_180",    ei(32'h180, 0, 3'b000, 8, OPIMM),            32'h0000_0180);
        add("nmul_pos",    er(7'd0, 8, 7, 3'b000, 9, OPCUST),           32'h0000_0300);
        add("addi_m512",   ei(-512, 0, 3'b000, 10, OPIMM),              32'hFFFF_FE00);
        add("nmul_neg",    er(7'd0, 8, 10, 3'b000, 11, OPCUST),         32'hFFFF_FD00);
        add("nact_0",      er(7'd0, 0, 0, 3'b001, 12, OPCUST),          32'h0000_0080);
        add("addi_100",    ei(32'h100, 0, 3'b000, 13, OPIMM),           32'h0000_0100);
        add("nact_100",    er(7'd0, 0, 13, 3'b001, 12, OPCUST),         32'h0000_00C0);
        add("addi_m256",   ei(-256, 0, 3'b000, 13, OPIMM),              32'hFFFF_FF00);
        add("nact_m100",   er(7'd0, 0, 13, 3'b001, 12, OPCUST),         32'h0000_0040);
        add("addi_500",    ei(32'h500, 0, 3'b000, 13, OPIMM),           32'h0000_0500);
        add("nact_500",    er(7'd0, 0, 13, 3'b001, 12, OPCUST),         32'h0000_0100);
        add("addi_300",    ei(32'h300, 0, 3'b000, 13, OPIMM),           32'h0000_0300);
        add("nact_300",    er(7'd0, 7, 13, 3'b001, 12, OPCUST),         32'h0000_00F0);
        add("sub",         er(7'b0100000, 1, 2, 3'b000, 14, OPREG),     32'hFFFF_FFF9);
        add("slt",         er(7'd0, 1, 2, 3'b010, 15, OPREG),           32'h0000_0001);
        add("sltu",        er(7'd0, 1, 2, 3'b011, 15, OPREG),           32'h0000_0000);
        add("srai",        ei(32'h401, 2, 3'b101, 16, OPIMM),           32'hFFFF_FFFF);
        add("srli",        ei(28, 2, 3'b101, 16, OPIMM),                32'h0000_000F);
        add("slli",        ei(4, 1, 3'b001, 16, OPIMM),                 32'h0000_0050);
        add("sra",         er(7'b0100000, 1, 2, 3'b101, 16, OPREG),     32'hFFFF_FFFF);
        add("srl",         er(7'd0, 1, 2, 3'b101, 16, OPREG),           32'h07FF_FFFF);
        add("xor",         er(7'd0, 2, 1, 3'b100, 17, OPREG),           32'hFFFF_FFFB);
        add("auipc",       eu(1, 18, OPAUI),                            32'(vecs.size() * 4 + 32'h1000));
        add("addi_x0",     ei(7, 0, 3'b000, 0, OPIMM),                  32'h0000_0007);
        add("add_x0_read", er(7'd0, 1, 0, 3'b000, 19, OPREG),           32'h0000_0005);
        add("addi_same",   ei(1, 1, 3'b000, 1, OPIMM),                  32'h0000_0006);
        add("cust_nop",    er(7'd0, 8, 7, 3'b010, 9, OPCUST),           32'h0000_0000);
        add("bgeu_nt",     eb(8, 2, 1, 3'b111),                         32'h0000_0000);
        add("andi",        ei(32'hF0, 2, 3'b111, 20, OPIMM),            32'h0000_00F0);

        for (int i = 0; i < vecs.size(); i++) begin
            load(i, vecs[i].instr);
        end
        // Code at word 100 is reached after a later reset to prove imem survives it.
        load(100, er(7'd0, 0, 3, 3'b000, 21, OPREG));
        load(101, ei(84, 0, 3'b010, 22, OPLOAD));
        load(102, ei(0, 2, 3'b000, 23, OPIMM));
        load(103, ei(32'h33, 0, 3'b000, 24, OPIMM));

        enb = 1'b1;
        @(negedge clk);
        chk("rst_over_enb", WB_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].name, vecs[i].wb);
        end

        // Reset with enb high; rewrite word 0 during reset to jump to word 100.
        rst = 1'b1;
        inst_wen  = 1'b1;
        inst_addr = 7'd0;
        inst_data = ej(400, 0);
        @(posedge clk);
        #1;
        inst_wen = 1'b0;
        @(negedge clk);
        chk("rst_wb_zero", WB_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("jal_x0_link", 32'h0000_0004);
        step("regs_cleared", 32'd0);
        step("dmem_cleared", 32'd0);
        step("x2_cleared", 32'd0);
        step("imem_kept", 32'h0000_0033);

        // Count loop: 1 + 10*2 executed instructions, then JAL over word 4.
        rst = 1'b1;
        enb = 1'b0;
        load(0, ei(10, 0, 3'b000, 5, OPIMM));
        load(1, ei(-1, 5, 3'b000, 5, OPIMM));
        load(2, eb(-4, 0, 5, 3'b001));
        load(3, ej(8, 1));
        load(4, ei(99, 0, 3'b000, 6, OPIMM));
        load(5, ei(32'h77, 0, 3'b000, 7, OPIMM));
        rst = 1'b0;
        enb = 1'b1;
        step("loop_init", 32'd10);
        for (int k = 9; k >= 0; k--) begin
            step("loop_dec", 32'(k));
            step("loop_bne", 32'd0);
        end
        step("jal_link", 32'd16);
        step("jal_target", 32'h0000_0077);

        // Freeze: PC and registers hold while enb is low.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("frz_init", 32'd10);
        step("frz_dec", 32'd9);
        step("frz_bne", 32'd0);
        enb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("frz_hold", 32'd0);
        end
        enb = 1'b1;
        step("frz_resume", 32'd8);
        step("frz_bne2", 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
